// File: rtl/cheri_err_pkg.sv
// Shared constants and event payload type for the CHERI error monitor.
package cheri_err_pkg;

  localparam int unsigned CheriErrBounds      = 0;
  localparam int unsigned Tag                 = 1;
  localparam int unsigned Seal                = 2;
  localparam int unsigned PermitExecute       = 3;
  localparam int unsigned PermitLoad          = 4;
  localparam int unsigned PermitStore         = 5;
  localparam int unsigned PermitStoreCap      = 6;
  localparam int unsigned PermitStoreLocalCap = 7;
  localparam int unsigned PermitAccSysRegs    = 8;

  localparam int unsigned NumErrDefault = 9;
  localparam int unsigned CountWDefault = 8;
  localparam int unsigned TsWDefault    = 32;
  localparam int unsigned IdxWDefault   = (NumErrDefault > 1) ? $clog2(NumErrDefault) : 1;

  // Event record as seen by a consumer of a default-sized monitor.
  typedef struct packed {
    logic [IdxWDefault-1:0] idx;
    logic [TsWDefault-1:0]  ts;
  } evt_t;

endpackage

// File: rtl/cheri_err_sat_counter.sv
// Per-channel saturating occurrence counter; clear wins over increment.
module cheri_err_sat_counter
  import cheri_err_pkg::*;
#(
  parameter int unsigned CountW = CountWDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [CountW-1:0] count_o
);

  logic [CountW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CountW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cheri_err_monitor.sv
// Latches first occurrence of each CHERI error channel with a timestamp, counts
// repeats, and streams one event record per first occurrence.
module cheri_err_monitor
  import cheri_err_pkg::*;
#(
  parameter int unsigned NumErr = NumErrDefault,
  parameter int unsigned CountW = CountWDefault,
  parameter int unsigned TsW    = TsWDefault,
  localparam int unsigned IdxW  = (NumErr > 1) ? $clog2(NumErr) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumErr-1:0]        err_i,
  input  logic [NumErr-1:0]        clr_i,
  input  logic                     irq_en_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [IdxW-1:0]          evt_idx_o,
  output logic [TsW-1:0]           evt_time_o,
  output logic [NumErr-1:0]        sticky_o,
  output logic [NumErr*CountW-1:0] count_o,
  output logic [NumErr-1:0]        pending_o,
  output logic                     irq_o
);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [TsW-1:0]  ts;
  } evt_rec_t;

  logic [NumErr-1:0] sticky_q, sticky_d;
  logic [NumErr-1:0] pending_q, pending_d;
  logic [NumErr-1:0] err_q, err_d;
  logic [TsW-1:0]    ts_q, ts_d;
  logic [TsW-1:0]    time_q [NumErr];
  logic [TsW-1:0]    time_d [NumErr];
  logic              evt_valid_q, evt_valid_d;
  evt_rec_t          evt_q, evt_d;
  logic              irq_q, irq_d;

  logic [NumErr-1:0] new_c, rise_c;
  logic [IdxW-1:0]   sel_c;
  logic              out_free_c;

  always_comb begin
    new_c      = err_i & ~sticky_q & ~clr_i;
    rise_c     = err_i & ~err_q & ~clr_i;
    err_d      = err_i;
    ts_d       = ts_q + TsW'(1);
    sticky_d   = (sticky_q | new_c) & ~clr_i;
    pending_d  = (pending_q | new_c) & ~clr_i;
    for (int e = 0; e < int'(NumErr); e++) begin
      time_d[e] = clr_i[e] ? '0 : (new_c[e] ? ts_q : time_q[e]);
    end

    // Lowest-index pending channel wins the output register.
    sel_c = '0;
    for (int i = int'(NumErr) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_c = IdxW'(i);
    end

    out_free_c  = ~evt_valid_q | evt_ready_i;
    evt_valid_d = evt_valid_q;
    evt_d       = evt_q;
    if (out_free_c) begin
      evt_valid_d = |pending_q;
      if (|pending_q) begin
        evt_d.idx          = sel_c;
        evt_d.ts           = time_q[sel_c];
        pending_d[sel_c]   = 1'b0;
      end
    end

    irq_d = irq_en_i & ((|pending_q) | evt_valid_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q    <= '0;
      pending_q   <= '0;
      err_q       <= '0;
      ts_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
      irq_q       <= 1'b0;
      for (int e = 0; e < int'(NumErr); e++) time_q[e] <= '0;
    end else begin
      sticky_q    <= sticky_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      ts_q        <= ts_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
      irq_q       <= irq_d;
      for (int e = 0; e < int'(NumErr); e++) time_q[e] <= time_d[e];
    end
  end

  for (genvar e = 0; e < NumErr; e++) begin : g_cnt
    cheri_err_sat_counter #(.CountW(CountW)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (rise_c[e]),
      .clr_i   (clr_i[e]),
      .count_o (count_o[e*CountW +: CountW])
    );
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_idx_o   = evt_q.idx;
  assign evt_time_o  = evt_q.ts;
  assign sticky_o    = sticky_q;
  assign pending_o   = pending_q;
  assign irq_o       = irq_q;

endmodule
